pipeline_stall_ctrl: RTL and testbench
======================================

# pipeline_stall_ctrl

Pipeline control block that consumes stall and redirect requests in the 5-stage RISC-V core and drives every pipeline-register write enable, the IF/ID flush and the ID/EX bubble insert. It takes the ID-stage `hazard` request, the ID-resolved `branch_taken`, and the data-memory `mem_busy`, and arbitrates them by fixed priority. It also tracks the current pipeline action in a state register, flags runaway stalls with a watchdog, and optionally counts stall, flush and freeze cycles for performance analysis.

## Interface
- `MAX_STALL`, 16, consecutive STALL/FREEZE cycles before `stall_timeout` sets; legal range 2..255.
- `CNT_WIDTH`, 32, width of each performance counter.
- `clk`  in  1  rising-edge clock.
- `arst_n`  in  1  asynchronous active-low reset.
- `hazard`  in  1  stall request from ID-stage hazard detection (load-use or branch-use); combinational, same cycle.
- `branch_taken`  in  1  branch/jump resolved taken in ID; redirect PC and kill IF/ID.
- `mem_busy`  in  1  data memory not ready; whole pipeline must hold.
- `pc_we`  out  1  PC register write enable.
- `if_id_we`  out  1  IF/ID register write enable.
- `if_id_flush`  out  1  load NOP into IF/ID on this edge.
- `id_ex_bubble`  out  1  load NOP (all control bits 0) into ID/EX on this edge.
- `ex_mem_we`  out  1  EX/MEM register write enable.
- `mem_wb_we`  out  1  MEM/WB register write enable.
- `state`  out  2  registered previous-cycle action: 0=RUN, 1=STALL, 2=FLUSH, 3=FREEZE.
- `stall_timeout`  out  1  sticky watchdog flag.
- `stall_cycles`, `flush_cycles`, `freeze_cycles`  out  CNT_WIDTH  performance counters.

## Operation
- Action selection is combinational, with priority `mem_busy` > `hazard` > `branch_taken` > none.
- FREEZE (`mem_busy`=1):
  - All four write enables are 0; `if_id_flush`=0; `id_ex_bubble`=0.
  - `hazard` and `branch_taken` are ignored and get re-evaluated after release.
- STALL (`hazard`=1, `mem_busy`=0):
  - `pc_we`=0, `if_id_we`=0, `id_ex_bubble`=1, `ex_mem_we`=1, `mem_wb_we`=1, `if_id_flush`=0.
  - `branch_taken` is ignored, because branch operands are stale.
- FLUSH (`branch_taken`=1 only): all write enables 1, `if_id_flush`=1, `id_ex_bubble`=0.
- RUN (no request): all write enables 1, `if_id_flush`=0, `id_ex_bubble`=0.
- `state` <= the selected action code on each rising edge.
- Watchdog run-length counter, width 8:
  - Increments on each STALL or FREEZE cycle, saturating at `MAX_STALL`.
  - Clears to 0 on a RUN or FLUSH cycle.
  - `stall_timeout` sets on the edge where the counter reaches `MAX_STALL`, and holds until reset.
  - The timeout only flags; it never forces the pipeline forward.
- While `arst_n`=0, all outputs are 0 (combinational enables included):
  - `state`=RUN, run-length=0, `stall_timeout`=0, counters=0.

## Timing
- Control outputs have zero latency: same-cycle combinational functions of `hazard`, `branch_taken`, `mem_busy` and `arst_n`. No input is registered.
- `state`, run-length, `stall_timeout` and counters update on the rising `clk` edge; they are visible one cycle after the triggering action.
- Reset assertion mid-operation clears everything immediately. Outputs follow the inputs from the first cycle after deassertion.
- Simultaneous `mem_busy` + `hazard` + `branch_taken` give FREEZE; after `mem_busy` drops, STALL or FLUSH follows if the requests persist.
- A one-cycle load-use stall gives exactly one `id_ex_bubble` and one held PC; no extra state is needed.

## Configuration
- `PIPE_PERF_CNT_EN` defined:
  - `stall_cycles`, `flush_cycles` and `freeze_cycles` each increment by 1 per cycle spent in their action.
  - Counters wrap modulo 2^`CNT_WIDTH` and clear on reset.
- `PIPE_PERF_CNT_EN` undefined:
  - Counter logic is removed and the three outputs are tied to 0.
  - Ports remain present; all other behaviour is unchanged.

## Test plan
- Reset then idle 5 cycles with all inputs 0 -> all enables 1, flush/bubble 0, `state`=0, `stall_timeout`=0.
- `hazard`=1 for 1 cycle -> that cycle `pc_we`=0, `if_id_we`=0, `id_ex_bubble`=1; next cycle `state`=1, then RUN; `stall_cycles`=1.
- `hazard`=1 and `branch_taken`=1 in the same cycle, then `branch_taken` alone -> first cycle STALL, second cycle `if_id_flush`=1 with `pc_we`=1; `flush_cycles`=1.
- `mem_busy`=1 for 3 cycles with `hazard`=1 -> all enables 0, bubble 0 for 3 cycles, then 1 STALL cycle; `freeze_cycles`=3.
- `MAX_STALL`=4, `hazard` held 5 cycles -> `stall_timeout` rises at the 4th edge and stays 1 after `hazard` drops until `arst_n` pulses low.
- `arst_n` pulled low mid-FREEZE -> outputs 0 immediately, counters and `state` cleared; recovery to RUN in the first cycle after release.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: fixed-priority stall/flush/freeze arbitration for the
// 5-stage core. Drives all pipeline-register write enables, the IF/ID flush
// and the ID/EX bubble, tracks the last action and runs a stall watchdog.
// Optional performance counters are compiled in with PIPE_PERF_CNT_EN.
module pipeline_stall_ctrl #(
  parameter int unsigned MAX_STALL = 16,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 hazard,
  input  logic                 branch_taken,
  input  logic                 mem_busy,
  output logic                 pc_we,
  output logic                 if_id_we,
  output logic                 if_id_flush,
  output logic                 id_ex_bubble,
  output logic                 ex_mem_we,
  output logic                 mem_wb_we,
  output logic [1:0]           state,
  output logic                 stall_timeout,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_cycles,
  output logic [CNT_WIDTH-1:0] freeze_cycles
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FLUSH  = 2'd2,
    FREEZE = 2'd3
  } action_t;

  localparam logic [7:0] MAX_RUN = 8'(MAX_STALL);

  action_t    act;
  action_t    state_q;
  logic [7:0] run_len;
  logic [7:0] run_len_next;
  logic       holding;

  // Priority select: mem_busy > hazard > branch_taken > none.
  always_comb begin
    act = RUN;
    if (mem_busy)          act = FREEZE;
    else if (hazard)       act = STALL;
    else if (branch_taken) act = FLUSH;
  end

  // Action state register (previous-cycle action).
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= RUN;
    else         state_q <= act;
  end

  // Control decode; everything forced low while reset is asserted.
  always_comb begin
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_we    = 1'b0;
    mem_wb_we    = 1'b0;
    if (arst_n) begin
      case (act)
        FREEZE: ;
        STALL: begin
          id_ex_bubble = 1'b1;
          ex_mem_we    = 1'b1;
          mem_wb_we    = 1'b1;
        end
        FLUSH: begin
          pc_we       = 1'b1;
          if_id_we    = 1'b1;
          if_id_flush = 1'b1;
          ex_mem_we   = 1'b1;
          mem_wb_we   = 1'b1;
        end
        default: begin
          pc_we     = 1'b1;
          if_id_we  = 1'b1;
          ex_mem_we = 1'b1;
          mem_wb_we = 1'b1;
        end
      endcase
    end
  end

  assign state   = state_q;
  assign holding = (act == STALL) || (act == FREEZE);

  // Saturating run-length of consecutive STALL/FREEZE cycles.
  always_comb begin
    run_len_next = '0;
    if (holding) begin
      if (run_len == MAX_RUN) run_len_next = run_len;
      else                    run_len_next = run_len + 8'd1;
    end
  end

  // Watchdog: sticky flag once the run length reaches MAX_STALL.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      run_len       <= '0;
      stall_timeout <= 1'b0;
    end else begin
      run_len <= run_len_next;
      if (run_len_next == MAX_RUN) stall_timeout <= 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Per-action cycle counters, wrapping.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cycles  <= '0;
      flush_cycles  <= '0;
      freeze_cycles <= '0;
    end else begin
      if (act == STALL)  stall_cycles  <= stall_cycles  + CNT_ONE;
      if (act == FLUSH)  flush_cycles  <= flush_cycles  + CNT_ONE;
      if (act == FREEZE) freeze_cycles <= freeze_cycles + CNT_ONE;
    end
  end
`else
  assign stall_cycles  = '0;
  assign flush_cycles  = '0;
  assign freeze_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl (MAX_STALL=4).
module tb_pipeline_stall_ctrl;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we}
  localparam logic [5:0] C_RUN    = 6'b110011;
  localparam logic [5:0] C_STALL  = 6'b000111;
  localparam logic [5:0] C_FLUSH  = 6'b111011;
  localparam logic [5:0] C_FREEZE = 6'b000000;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        hazard = 1'b0, branch_taken = 1'b0, mem_busy = 1'b0;
  logic        pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we;
  logic [1:0]  state;
  logic        stall_timeout;
  logic [31:0] stall_cycles, flush_cycles, freeze_cycles;
  logic [5:0]  ctl;

  int unsigned checks = 0;
  int unsigned failures = 0;

  pipeline_stall_ctrl #(.MAX_STALL(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .arst_n(arst_n), .hazard(hazard), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .pc_we(pc_we), .if_id_we(if_id_we),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we), .state(state),
    .stall_timeout(stall_timeout), .stall_cycles(stall_cycles),
    .flush_cycles(flush_cycles), .freeze_cycles(freeze_cycles)
  );

  assign ctl = {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mb, input logic hz, input logic bt);
    mem_busy = mb;
    hazard = hz;
    branch_taken = bt;
    #1;
  endtask

  function automatic logic [31:0] pc(input int unsigned n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic do_reset();
    step();
    arst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    check("rst_ctl", 32'(ctl), 32'(C_FREEZE));
    check("rst_state", 32'(state), 32'd0);
    check("rst_tmo", 32'(stall_timeout), 32'd0);
    step();
    arst_n = 1'b1;
    #1;
  endtask

  initial begin
    do_reset();

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      check("idle_ctl", 32'(ctl), 32'(C_RUN));
      step();
      check("idle_state", 32'(state), 32'd0);
      check("idle_tmo", 32'(stall_timeout), 32'd0);
    end

    // Single-cycle load-use stall
    drive(1'b0, 1'b1, 1'b0);
    check("ld_use_ctl", 32'(ctl), 32'(C_STALL));
    step();
    drive(1'b0, 1'b0, 1'b0);
    check("ld_use_state", 32'(state), 32'd1);
    check("ld_use_run", 32'(ctl), 32'(C_RUN));
    step();
    check("ld_use_state2", 32'(state), 32'd0);
    check("ld_use_cnt", stall_cycles, pc(1));

    // Hazard masks branch, then branch alone flushes
    do_reset();
    drive(1'b0, 1'b1, 1'b1);
    check("hz_br_ctl", 32'(ctl), 32'(C_STALL));
    step();
    drive(1'b0, 1'b0, 1'b1);
    check("hz_br_state", 32'(state), 32'd1);
    check("flush_ctl", 32'(ctl), 32'(C_FLUSH));
    step();
    drive(1'b0, 1'b0, 1'b0);
    check("flush_state", 32'(state), 32'd2);
    check("flush_cnt", flush_cycles, pc(1));
    check("flush_stall_cnt", stall_cycles, pc(1));

    // Freeze for 3 cycles with hazard pending, then one stall
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      check("frz_ctl", 32'(ctl), 32'(C_FREEZE));
      step();
      check("frz_state", 32'(state), 32'd3);
      check("frz_tmo", 32'(stall_timeout), 32'd0);
    end
    drive(1'b0, 1'b1, 1'b0);
    check("post_frz_ctl", 32'(ctl), 32'(C_STALL));
    step();
    drive(1'b0, 1'b0, 1'b0);
    check("post_frz_state", 32'(state), 32'd1);
    check("frz_cnt", freeze_cycles, pc(3));
    check("frz_stall_cnt", stall_cycles, pc(1));
    check("frz_stall_tmo", 32'(stall_timeout), 32'd1);
    check("frz_run_ctl", 32'(ctl), 32'(C_RUN));

    // Watchdog: hazard held 5 cycles, flag rises at the 4th edge and sticks
    do_reset();
    check("wd_cleared", 32'(stall_timeout), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      check("wd_ctl", 32'(ctl), 32'(C_STALL));
      step();
      check("wd_tmo", 32'(stall_timeout), (i >= 4) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      check("wd_run_ctl", 32'(ctl), 32'(C_RUN));
      step();
      check("wd_sticky", 32'(stall_timeout), 32'd1);
    end
    check("wd_stall_cnt", stall_cycles, pc(5));

    // Reset mid-freeze
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    step();
    step();
    check("mid_frz_state", 32'(state), 32'd3);
    check("mid_frz_cnt", freeze_cycles, pc(2));
    arst_n = 1'b0;
    #1;
    check("mid_rst_ctl", 32'(ctl), 32'(C_FREEZE));
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_cnt", freeze_cycles, 32'd0);
    step();
    arst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    check("recover_ctl", 32'(ctl), 32'(C_RUN));
    step();
    check("recover_state", 32'(state), 32'd0);
    check("recover_tmo", 32'(stall_timeout), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
